// File: rtl/axi_pkg.sv
// ============================================================================
// Module  : axi_pkg
// Purpose : Shared AXI read-side encodings and the read-master FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_read_master.sv
// ============================================================================
// Module  : axi_read_master
// Purpose : Single-burst AXI INCR read master streaming R beats downstream.
//           Define AXI_RD_RESP_CHECK_EN to enable the sticky rresp/rlast check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_master
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done,
  output logic                     err
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

  rd_state_t  state;
  rd_state_t  next_state;
  logic [8:0] beat_cnt;
  logic       cmd_accept;
  logic       beat_accept;
  logic       last_beat;

  assign arsize      = SIZE_LOG2[2:0];
  assign arburst     = BURST_INCR;
  assign out_data    = rdata;
  assign cmd_accept  = (state == ST_IDLE) && cmd_valid;
  assign beat_accept = (state == ST_DATA) && rvalid && out_ready;
  assign last_beat   = (beat_cnt == {1'b0, arlen});

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address/length stay frozen from command accept until the next command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      araddr   <= '0;
      arlen    <= '0;
      beat_cnt <= '0;
    end else if (cmd_accept) begin
      araddr   <= cmd_addr;
      arlen    <= cmd_len;
      beat_cnt <= '0;
    end else if (beat_accept && !last_beat) begin
      beat_cnt <= beat_cnt + 9'd1;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) next_state = ST_DATA;
      end
      ST_DATA: begin
        rready    = out_ready;
        out_valid = rvalid;
        out_last  = last_beat;
        // Burst length is owned by arlen; rlast never terminates the burst.
        if (beat_accept && last_beat) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef AXI_RD_RESP_CHECK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err <= 1'b0;
    end else if (cmd_accept) begin
      err <= 1'b0;
    end else if (beat_accept && ((rresp != RESP_OKAY) || (rlast != last_beat))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast};
  assign err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, the byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the R data width (power of two, 8..1024).
REQ-003 SHALL have port aclk  in  1  as the single clock; all state on rising edge.
REQ-004 SHALL have port aresetn  in  1  as the reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid  in  1  to request a read burst.
REQ-006 SHALL have port cmd_ready  out  1  to accept the command.
REQ-007 SHALL have port cmd_addr  in  ADDRESS_WIDTH  as the burst start address.
REQ-008 SHALL have port cmd_len  in  8  as the beat count minus one.
REQ-009 SHALL have port araddr  out  ADDRESS_WIDTH  as the AR address.
REQ-010 SHALL have port arlen  out  8  as the AR length.
REQ-011 SHALL have port arsize  out  3  as the AR size, constant log2(DATA_WIDTH/8).
REQ-012 SHALL have port arburst  out  2  as the AR burst, constant INCR (2'b01).
REQ-013 SHALL have port arvalid  out  1  and port arready  in  1  as the AR handshake.
REQ-014 SHALL have port rdata  in  DATA_WIDTH  and port rresp  in  2  as R payload.
REQ-015 SHALL have port rlast  in  1  to mark the final R beat.
REQ-016 SHALL have port rvalid  in  1  and port rready  out  1  as the R handshake.
REQ-017 SHALL have port out_data  out  DATA_WIDTH  with out_valid out 1, out_ready in 1, out_last out 1 as the downstream stream.
REQ-018 SHALL have port done  out  1  to pulse at burst end, and port err  out  1  as the sticky error flag.

Function
REQ-019 SHALL implement FSM IDLE, ADDR, DATA, DONE.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, latch addr/len into araddr/arlen, clear beat counter, go ADDR.
REQ-021 ADDR: arvalid=1, araddr/arlen stable until arready; on arvalid&&arready go DATA the next cycle.
REQ-022 DATA: rready=out_ready, out_valid=rvalid, out_data=rdata combinationally; beat accepted when rvalid&&rready.
REQ-023 SHALL count accepted beats in a 9-bit counter; out_last=1 when counter equals arlen.
REQ-024 On the accepted beat where counter equals arlen, go DONE, regardless of rlast.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=0 in ADDR, DATA, DONE.
REQ-026 A new command accepted in IDLE SHALL issue arvalid no later than the following cycle (one-cycle command-to-AR latency).
REQ-027 cmd_len=0 SHALL produce a single-beat burst with out_last on the first beat.
REQ-028 rready and out_valid SHALL be 0 outside DATA; R beats outside DATA are ignored.

Reset
REQ-029 aresetn low SHALL force IDLE and clear araddr, arlen, counter, arvalid, rready, out_valid, out_last, done, err to 0 immediately, including mid-burst.
REQ-030 After reset release, the first command SHALL be accepted no earlier than the first rising edge with aresetn high.

Configuration
REQ-031 With AXI_RD_RESP_CHECK_EN defined, err SHALL set when an accepted beat has rresp!=OKAY or rlast disagrees with out_last, and clear only on the next cmd accept.
REQ-032 Without AXI_RD_RESP_CHECK_EN, err SHALL be tied 0 and rresp/rlast SHALL be unused.

Structure
REQ-033 SHALL import a shared package axi_pkg holding FSM state enum, burst constants (FIXED/INCR/WRAP) and resp constants (OKAY/EXOKAY/SLVERR/DECERR).
REQ-034 SHALL be a single module; no sub-module.

Verification
REQ-035 cmd_addr=8'h10, cmd_len=5, arready after 2 cycles -> araddr=8'h10, arlen=5, arsize=2, arburst=1 held; 6 beats out, out_last on 6th, done 1 cycle.
REQ-036 cmd_len=0, arready immediate -> one beat with out_last=1, done next cycle.
REQ-037 out_ready toggled every other cycle over 4-beat burst -> rready tracks out_ready, no beat lost or duplicated.
REQ-038 aresetn low during beat 3 of 6 -> all outputs 0 asynchronously, FSM IDLE, next command runs cleanly.
REQ-039 With AXI_RD_RESP_CHECK_EN: rresp=2'b10 on beat 2, or rlast on beat 1 of 4 -> err=1 held until next cmd accept; without macro err stays 0.
